// File: rtl/led_mmio_pkg.sv
// Register map, response type and STATUS bit positions shared by the LED MMIO
// peripheral and its blink prescaler.
package led_mmio_pkg;

  localparam logic [4:0] OFF_LED_OUT      = 5'h00;
  localparam logic [4:0] OFF_LED_SET      = 5'h04;
  localparam logic [4:0] OFF_LED_CLR      = 5'h08;
  localparam logic [4:0] OFF_BLINK_MASK   = 5'h0C;
  localparam logic [4:0] OFF_BLINK_PERIOD = 5'h10;
  localparam logic [4:0] OFF_STATUS       = 5'h14;

  localparam int STATUS_PHASE_BIT    = 0;
  localparam int STATUS_BLINK_EN_BIT = 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

endpackage

// File: rtl/blink_prescaler.sv
// Free-running blink prescaler: phase toggles every 'period' cycles while
// period is non-zero; a period write restarts the count without toggling.
module blink_prescaler #(
  parameter int PRESC_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PRESC_W-1:0] period,
  input  logic               period_wr,
  output logic               phase
);

  logic [PRESC_W-1:0] cnt;

  // A period write takes priority over a wrap so the new period starts cleanly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (period_wr) begin
      cnt <= '0;
    end else if (period == '0) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == period - PRESC_W'(1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/led_mmio.sv
// Memory-mapped LED peripheral: decodes a 32-byte window, holds LED and blink
// state, answers each accepted request with one registered response.
module led_mmio
  import led_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LED_W     = 16,
  parameter int          PRESC_W   = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_be,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [LED_W-1:0] LEDS
);

  logic [LED_W-1:0]   led_out;
  logic [LED_W-1:0]   blink_mask;
  logic [PRESC_W-1:0] blink_period;
  logic               phase;
  logic               accept;
  logic               addr_ok;
  logic               wr;
  logic               period_wr;
  logic [4:0]         offset;
  logic [31:0]        be_mask;
  logic [LED_W-1:0]   led_be_mask;
  logic [LED_W-1:0]   led_wdata;
  rsp_t               rsp_q;
  rsp_t               rsp_d;
  logic               unused_bits;

  assign req_ready   = !rsp_valid || rsp_ready;
  assign accept      = req_valid && req_ready;
  assign addr_ok     = (req_addr[31:5] == BASE_ADDR[31:5]) && (req_addr[1:0] == 2'b00);
  assign offset      = {req_addr[4:2], 2'b00};
  assign wr          = accept && req_we && addr_ok;
  assign period_wr   = wr && (offset == OFF_BLINK_PERIOD);
  assign be_mask     = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
  assign led_be_mask = be_mask[LED_W-1:0];
  assign led_wdata   = req_wdata[LED_W-1:0] & led_be_mask;
  assign unused_bits = ^{req_wdata, be_mask};

  // Read data is taken from pre-write state; writes and errors return zero.
  always_comb begin
    rsp_d = '0;
    if (!addr_ok) begin
      rsp_d.err = 1'b1;
    end else if (!req_we) begin
      case (offset)
        OFF_LED_OUT:      rsp_d.rdata = 32'(led_out);
        OFF_BLINK_MASK:   rsp_d.rdata = 32'(blink_mask);
        OFF_BLINK_PERIOD: rsp_d.rdata = 32'(blink_period);
        OFF_STATUS: begin
          rsp_d.rdata[STATUS_PHASE_BIT]    = phase;
          rsp_d.rdata[STATUS_BLINK_EN_BIT] = (blink_period != '0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_out      <= '0;
      blink_mask   <= '0;
      blink_period <= '0;
    end else if (wr) begin
      case (offset)
        OFF_LED_OUT:      led_out    <= (led_out & ~led_be_mask) | led_wdata;
        OFF_LED_SET:      led_out    <= led_out | led_wdata;
        OFF_LED_CLR:      led_out    <= led_out & ~led_wdata;
        OFF_BLINK_MASK:   blink_mask <= (blink_mask & ~led_be_mask) | led_wdata;
        OFF_BLINK_PERIOD: blink_period <= (blink_period & ~be_mask[PRESC_W-1:0])
                                        | (req_wdata[PRESC_W-1:0] & be_mask[PRESC_W-1:0]);
        default: ;
      endcase
    end
  end

  // Response is held until consumed; a new accept overwrites it in the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_q     <= rsp_d;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end
  end

  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      LEDS <= '0;
    end else begin
      LEDS <= led_out ^ (blink_mask & {LED_W{phase}});
    end
  end

  blink_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .period    (blink_period),
    .period_wr (period_wr),
    .phase     (phase)
  );

endmodule

// File: doc/led_mmio.md
Name: led_mmio

Overview:
Memory-mapped LED peripheral that sits between the rv32i_seg core's data-memory port and the 16-bit LEDS output of fpga_top. The core drives the block with word-aligned loads and stores. The block holds the LED state and an optional hardware blink pattern, and drives LEDS directly. It decodes its own address window and answers every accepted request with exactly one response one cycle later.

Parameters:
BASE_ADDR, 32'h8000_0000, base of the 32-byte register window; bits [4:0] must be zero.
LED_W, 16, LED output width; must be at most 16.
PRESC_W, 24, width of the blink prescaler counter and BLINK_PERIOD register.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = write, 0 = read
req_addr  in  32  byte address
req_wdata  in  32  write data
req_be  in  4  byte enables for writes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  32  read data; 0 for writes and errors
rsp_err  out  1  address error flag
LEDS  out  LED_W  LED pins

Behaviour:
- Reset: the synchronous active-low reset (rst_n sampled low on a clk edge) clears all registers and counters. Reset values:
  - outputs: rsp_valid=0, rsp_rdata=0, rsp_err=0, LEDS=0.
  - req_ready=1.
  - internal: LED_OUT=0, BLINK_MASK=0, BLINK_PERIOD=0, cnt=0, phase=0.
- Reset asserted mid-transaction drops any pending response without completing it.
- Register map (byte offsets from BASE_ADDR):
  - 0x00 LED_OUT: RW, bits [LED_W-1:0].
  - 0x04 LED_SET: W1S on LED_OUT; reads 0.
  - 0x08 LED_CLR: W1C on LED_OUT; reads 0.
  - 0x0C BLINK_MASK: RW, bits [LED_W-1:0].
  - 0x10 BLINK_PERIOD: RW, bits [PRESC_W-1:0].
  - 0x14 STATUS: RO; bit0 = phase, bit1 = blink_en (BLINK_PERIOD != 0); writes ignored.
  - 0x18 and 0x1C: reserved; read 0, writes ignored, rsp_err=0.
- Unimplemented register bits read 0.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready; at most one request outstanding.
  - A request accepted at edge N produces rsp_valid=1 from edge N, with rdata and err valid.
  - The response holds stable until rsp_ready=1.
  - Back-to-back requests complete at full throughput while rsp_ready stays 1.
- Address error:
  - Condition: req_addr[31:5] != BASE_ADDR[31:5], or req_addr[1:0] != 0.
  - Response: rsp_err=1, rsp_rdata=0, no register side effect.
- Byte enables:
  - be[0] gates bits [7:0] and be[1] gates bits [15:8] for LED_OUT, LED_SET, LED_CLR and BLINK_MASK.
  - For BLINK_PERIOD, be[n] gates byte n.
  - be=0 write is a legal no-op with rsp_err=0.
- Blink prescaler:
  - When BLINK_PERIOD == 0: cnt=0 and phase=0 are held.
  - Otherwise cnt increments each cycle. When cnt == BLINK_PERIOD-1, cnt wraps to 0 and phase toggles. Half-period is therefore BLINK_PERIOD cycles.
  - Any accepted write to BLINK_PERIOD clears cnt to 0 and leaves phase unchanged. A write in the same cycle as a wrap wins: cnt=0, no toggle.
  - Reducing BLINK_PERIOD below the current cnt is safe: the write clears cnt.
- Output function: LEDS = LED_OUT ^ (BLINK_MASK & {LED_W{phase}}), registered, one-cycle latency from the register update.

Decomposition:
- Package led_mmio_pkg:
  - register offset localparams (OFF_LED_OUT … OFF_STATUS)
  - rsp struct typedef {rdata, err}
  - STATUS bit-index constants
- Sub-module blink_prescaler:
  - parameters: PRESC_W
  - inputs: clk, rst_n, period, period_wr
  - output: phase

Test Plan:
- Reset: hold rst_n=0 for 2 clk edges with req_valid=1 -> LEDS=0, rsp_valid=0, req_ready=1 throughout; after release, read 0x00 returns 0.
- Write 0x8000_0000 data 0xA5A5 be=4'b0001 -> LEDS=0x00A5 one cycle after response. Then write SET 0x0F00 be=4'b0011 -> LEDS=0x0FA5. Then CLR 0x0005 -> LEDS=0x0FA0.
- BLINK_MASK=0x00FF, BLINK_PERIOD=4, LED_OUT=0 -> LEDS toggles between 0x0000 and 0x00FF every 4 cycles; STATUS bit1=1.
- Write BLINK_PERIOD on the exact wrap cycle -> no phase toggle that cycle, next toggle 4 cycles later. Write period 0 -> phase frozen at 0, LEDS=LED_OUT.
- Read 0x8000_0040 and 0x8000_0002 -> rsp_err=1, rdata=0, no register change.
- Backpressure: rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, response stable, second request accepted the cycle rsp_ready=1.
